fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter, drives the 13-bit byte address into the instruction memory, and captures the returned 32-bit word (combinational read, same cycle).
- Buffers {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush the buffer.

Parameters:
- ADDR_W, 13, byte-address width; matches the instruction memory (8 KiB, 2048 words).
- DEPTH, 2, fetch-buffer entries; power of two, minimum 2.
- RESET_PC, 13'h0000, PC value loaded at reset; must be word-aligned.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- imem_addr_o  out  ADDR_W  byte address to instruction memory; combinational from PC register.
- imem_data_i  in  32  instruction word returned same cycle.
- redirect_i  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc_i  in  ADDR_W  redirect target byte address.
- instr_o  out  32  instruction at FIFO head.
- pc_o  out  ADDR_W  PC of instr_o.
- valid_o  out  1  FIFO head holds a valid entry.
- ready_i  in  1  decode accepts the head this cycle.
- misalign_o  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async assert, rst_ni=0):
  - pc <= RESET_PC; FIFO read/write pointers and count <= 0.
  - valid_o=0, instr_o=0, pc_o=RESET_PC, misalign_o=0. imem_addr_o follows pc (RESET_PC).
  - Deassertion is seen synchronously at the next edge.
- imem_addr_o = pc at all times.
- Events in a cycle:
  - pop = valid_o & ready_i.
  - push = ~redirect_i & (count < DEPTH | pop).
  - Push writes {pc, imem_data_i} at the write pointer and sets pc <= pc + 4.
- PC arithmetic is ADDR_W bits, modulo 2^ADDR_W: 13'h1FFC + 4 -> 13'h0000. No carry out, no error.
- Full: with count==DEPTH and no pop, no push occurs and pc holds. With count==DEPTH and a pop, push and pop occur in the same cycle and count is unchanged.
- Empty: valid_o=0; ready_i is ignored. There is no bypass: the first instruction appears one cycle after it is fetched, so fetch-to-decode latency is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Redirect (redirect_i=1), highest priority:
  - A head handshake in the same cycle (pop) completes and counts as consumed.
  - All entries are discarded: count <= 0, pointers <= 0.
  - No push occurs that cycle.
  - pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - misalign_o is 1 in the following cycle iff redirect_pc_i[1:0] != 0; otherwise 0.
  - Next cycle: the target word is fetched and valid_o rises one cycle after that.
- Back-to-back redirects: the last one wins; each flushes again.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- instr_o and pc_o come straight from the FIFO head register (no combinational path from imem_data_i). When valid_o=0 they hold stale contents and are don't-care.
- Reset mid-operation: all state returns to reset values immediately, and any buffered entries are lost.

Decomposition:
- Shared package riscv_pkg: ADDR_W, INSTR_W=32, RESET_PC, and typedef fetch_entry_t packed struct {logic [ADDR_W-1:0] pc; logic [31:0] instr;}.
- One sub-module: fetch_fifo, a generic DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count. It has the same clk_i/rst_ni convention.
- The PC register, push/pop logic and redirect logic live in fetch_unit.

Test Plan:
- Reset, then ready_i=1 with imem returning mem[addr>>2] = 32'h00300193, 32'h00500213, ... -> valid_o rises cycle 1 with pc_o=0, instr_o=32'h00300193; pc_o increments by 4 every cycle with no bubbles.
- ready_i=0 for 5 cycles -> count saturates at 2; imem_addr_o stalls at 13'h0008; ready_i=1 then delivers pc 0x0, 0x4, 0x8 in order with no loss or duplication.
- Redirect to 13'h0100 while FIFO holds 2 entries and ready_i=1 -> current head consumed; next valid entry has pc_o=13'h0100; both stale entries never appear.
- redirect_pc_i=13'h0102 -> misalign_o pulses 1 for one cycle; fetch resumes at 13'h0100.
- Redirect to 13'h1FF8 with ready_i=1 -> pc_o sequence 13'h1FF8, 13'h1FFC, 13'h0000, 13'h0004.
- Assert rst_ni=0 asynchronously mid-stream with FIFO full -> valid_o=0 and imem_addr_o=RESET_PC before the next clock edge; after release the fetch restarts from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice: address width, reset PC and the
// {pc, instr} entry carried from fetch to decode.
package riscv_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 13'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; the head is read straight from
// the storage register so the output has no combinational path from the write data.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned  DEPTH       = 2,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_ENTRY;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, buffers {pc, instr}
// pairs for decode and handles branch/jump redirects by flushing the buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [ADDR_W-1:0]   imem_addr_o,
  input  logic [INSTR_W-1:0]  imem_data_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                misalign_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              push, pop, full, empty;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      wr_entry, head;

  assign imem_addr_o = pc_q;
  assign valid_o     = ~empty;
  assign pop         = valid_o & ready_i;
  // Redirect wins over fetch: the in-flight word belongs to the wrong path.
  assign push        = ~redirect_i & ((count < DEPTH_C) | pop);

  assign wr_entry = '{pc: pc_q, instr: imem_data_i};
  assign instr_o  = head.instr;
  assign pc_o     = head.pc;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      misalign_d = (redirect_pc_i[1:0] != 2'b00);
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;

  fetch_fifo #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (fetch_entry_t'{pc: RESET_PC, instr: '0})
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  full_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    full |-> (!push || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// ready/redirect traffic checked every cycle against a queue-based model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [12:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [12:0] redirect_pc = '0;
  logic [31:0] instr;
  logic [12:0] pc;
  logic        valid;
  logic        ready = 1'b0;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  fetch_entry_t q[$];
  logic [12:0]  m_pc;
  logic         m_mis;

  function automatic logic [31:0] mem_word(input logic [12:0] a);
    return 32'h00300193 + 32'(a[12:2]) * 32'h00200080;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (13'h0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .pc_o          (pc),
    .valid_o       (valid),
    .ready_i       (ready),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = 13'h0000;
    m_mis = 1'b0;
  endtask

  task automatic check_model();
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("valid", 32'(valid), 32'(q.size() != 0));
    chk("misalign", 32'(misalign), 32'(m_mis));
    if (q.size() != 0) begin
      chk("pc_o", 32'(pc), 32'(q[0].pc));
      chk("instr_o", instr, q[0].instr);
    end
  endtask

  // Called at a negedge: apply inputs, advance the model across the edge, check.
  task automatic step(input logic rdy, input logic rd, input logic [12:0] tgt);
    ready       = rdy;
    redirect    = rd;
    redirect_pc = tgt;
    @(posedge clk);
    if (rd) begin
      q.delete();
      m_pc  = {tgt[12:2], 2'b00};
      m_mis = (tgt[1:0] != 2'b00);
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      m_mis = 1'b0;
      if (q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 13'd4;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 13'($urandom));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc_o", 32'(pc), 32'h0000);
    chk("rst_instr_o", instr, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
    chk("rst_misalign", 32'(misalign), 32'd0);
    check_model();
    rst_ni = 1'b1;

    // Streaming with no bubbles.
    step(1'b1, 1'b0, '0);
    chk("first_pc", 32'(pc), 32'h0000);
    chk("first_instr", instr, 32'h00300193);
    step(1'b1, 1'b0, '0);
    chk("second_pc", 32'(pc), 32'h0004);
    chk("second_instr", instr, 32'h00500213);
    step(1'b1, 1'b0, '0);
    chk("third_pc", 32'(pc), 32'h0008);

    // Stall: buffer saturates, fetch address holds.
    repeat (5) step(1'b0, 1'b0, '0);
    chk("stall_addr", 32'(imem_addr), 32'h0010);
    chk("stall_head", 32'(pc), 32'h0008);
    step(1'b1, 1'b0, '0);
    chk("drain_pc0", 32'(pc), 32'h000C);
    step(1'b1, 1'b0, '0);
    chk("drain_pc1", 32'(pc), 32'h0010);

    // Redirect with a full buffer and a head handshake.
    step(1'b1, 1'b1, 13'h0100);
    chk("redir_valid", 32'(valid), 32'd0);
    chk("redir_mis", 32'(misalign), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("redir_pc", 32'(pc), 32'h0100);

    // Misaligned target.
    step(1'b1, 1'b1, 13'h0102);
    chk("mis_pulse", 32'(misalign), 32'd1);
    step(1'b1, 1'b0, '0);
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_pc", 32'(pc), 32'h0100);

    // PC wraps modulo 2^13.
    step(1'b1, 1'b1, 13'h1FF8);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc0", 32'(pc), 32'h1FF8);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc1", 32'(pc), 32'h1FFC);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc2", 32'(pc), 32'h0000);
    step(1'b1, 1'b0, '0);
    chk("wrap_pc3", 32'(pc), 32'h0004);

    // Back-to-back redirects: last one wins.
    step(1'b1, 1'b1, 13'h0200);
    step(1'b1, 1'b1, 13'h0300);
    step(1'b1, 1'b0, '0);
    chk("b2b_pc", 32'(pc), 32'h0300);

    random_steps(300);

    // Asynchronous reset mid-stream with a full buffer.
    repeat (3) step(1'b0, 1'b0, '0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'h0000);
    chk("arst_pc_o", 32'(pc), 32'h0000);
    chk("arst_mis", 32'(misalign), 32'd0);
    model_reset();
    @(negedge clk);
    check_model();
    rst_ni = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("restart_pc", 32'(pc), 32'h0000);
    chk("restart_instr", instr, 32'h00300193);

    random_steps(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
